// File: rtl/split_network_if.sv
// rtl/split_network_if.sv - serial-in / lane-group-out handshake bundle for split_network
interface split_network_if #(
  parameter int NUM_OUTPUTS = 18,
  parameter int BIT_WIDTH   = 8
);
  localparam int CNT_WIDTH = $clog2(NUM_OUTPUTS + 1);

  logic                             in_valid;
  logic                             in_ready;
  logic [BIT_WIDTH-1:0]             in_data;
  logic                             in_last;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_OUTPUTS*BIT_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]             out_count;

  // Environment side: produces elements, consumes groups.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  // Splitter side: consumes elements, produces groups.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/split_network.sv
// rtl/split_network.sv - steers a serial element stream into zero-padded parallel lane groups
module split_network #(
  parameter int NUM_OUTPUTS = 18,
  parameter int BIT_WIDTH   = 8
) (
  input logic           clk,
  input logic           rst,
  split_network_if.slave bus
);
  localparam int CNT_WIDTH  = $clog2(NUM_OUTPUTS + 1);
  localparam int DATA_WIDTH = NUM_OUTPUTS * BIT_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  idx, idx_next;
  logic [CNT_WIDTH-1:0]  count, count_next;
  logic [DATA_WIDTH-1:0] data, data_next;
  logic                  in_ready, out_valid, in_fire, out_fire;

  // While a group is held, input readiness follows the consumer so the first
  // element of the next group can land in the same cycle the held group leaves.
  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = !rst && ((state == FILL) || bus.out_ready);
    in_fire   = bus.in_valid && in_ready;
    out_fire  = out_valid && bus.out_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = data;
  assign bus.out_count = count;

  // Next-state, lane steering and group bookkeeping.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    count_next = count;
    data_next  = data;
    case (state)
      FILL: begin
        if (in_fire) begin
          for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (idx == CNT_WIDTH'(i)) begin
              data_next[i*BIT_WIDTH +: BIT_WIDTH] = bus.in_data;
            end
          end
          if (idx == LAST_IDX || bus.in_last) begin
            state_next = HOLD;
            count_next = idx + ONE;
            idx_next   = '0;
          end else begin
            idx_next = idx + ONE;
          end
        end
      end
      HOLD: begin
        if (out_fire) begin
          // Clearing on consumption is what keeps unfilled lanes at zero.
          data_next  = '0;
          count_next = '0;
          idx_next   = '0;
          state_next = FILL;
          if (in_fire) begin
            data_next[BIT_WIDTH-1:0] = bus.in_data;
            if (NUM_OUTPUTS == 1 || bus.in_last) begin
              state_next = HOLD;
              count_next = ONE;
            end else begin
              idx_next = ONE;
            end
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // State and datapath registers; reset drops any partial or held group.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      count <= '0;
      data  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      count <= count_next;
      data  <= data_next;
    end
  end
endmodule

// File: tb/tb_split_network.sv
// tb/tb_split_network.sv - directed self-checking bench for split_network
module tb_split_network;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  split_network_if #(.NUM_OUTPUTS(4), .BIT_WIDTH(8)) bus_a ();
  split_network_if #(.NUM_OUTPUTS(1), .BIT_WIDTH(8)) bus_b ();

  split_network #(.NUM_OUTPUTS(4), .BIT_WIDTH(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  split_network #(.NUM_OUTPUTS(1), .BIT_WIDTH(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_a();
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    bus_a.in_data  = '0;
  endtask

  // Offers one element to dut_a and returns at the negedge after it is taken.
  task automatic push_a(input logic [7:0] d, input logic last, output int stalls);
    stalls = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.in_last  = last;
    #1;
    while (!bus_a.in_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!bus_a.in_ready) check("push_timeout", bus_a.in_ready, 1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int s;
    int stalls_total;
    logic [31:0] exp_grp [3];
    logic [7:0]  b_vals [3];
    exp_grp = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    b_vals  = '{8'h10, 8'h20, 8'h30};

    rst = 1'b1;
    idle_a();
    bus_a.out_ready = 1'b0;
    bus_b.in_valid  = 1'b0;
    bus_b.in_last   = 1'b0;
    bus_b.in_data   = '0;
    bus_b.out_ready = 1'b0;
    #3;
    check("rst_in_ready",  bus_a.in_ready,  0);
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_data",  bus_a.out_data,  0);
    check("rst_out_count", bus_a.out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("fill_in_ready", bus_a.in_ready, 1);

    // Full group
    bus_a.out_ready = 1'b1;
    push_a(8'h11, 1'b0, s);
    push_a(8'h22, 1'b0, s);
    push_a(8'h33, 1'b0, s);
    check("t1_valid_early", bus_a.out_valid, 0);
    push_a(8'h44, 1'b0, s);
    idle_a();
    #1;
    check("t1_valid", bus_a.out_valid, 1);
    check("t1_data",  bus_a.out_data,  32'h44332211);
    check("t1_count", bus_a.out_count, 4);
    step();
    check("t1_consumed_valid", bus_a.out_valid, 0);
    check("t1_cleared_data",   bus_a.out_data,  0);
    check("t1_cleared_count",  bus_a.out_count, 0);

    // Early terminate, in_last on final lane, then a short group after a full one
    push_a(8'hA1, 1'b0, s);
    push_a(8'hA2, 1'b1, s);
    idle_a();
    #1;
    check("t2_early_valid", bus_a.out_valid, 1);
    check("t2_early_data",  bus_a.out_data,  32'h0000A2A1);
    check("t2_early_count", bus_a.out_count, 2);
    step();
    push_a(8'hB1, 1'b0, s);
    push_a(8'hB2, 1'b0, s);
    push_a(8'hB3, 1'b0, s);
    push_a(8'hB4, 1'b1, s);
    idle_a();
    #1;
    check("t2_full_data",  bus_a.out_data,  32'hB4B3B2B1);
    check("t2_full_count", bus_a.out_count, 4);
    step();
    push_a(8'hC1, 1'b1, s);
    idle_a();
    #1;
    check("t2_single_data",  bus_a.out_data,  32'h000000C1);
    check("t2_single_count", bus_a.out_count, 1);
    step();

    // Backpressure with a pending element
    bus_a.out_ready = 1'b0;
    push_a(8'h31, 1'b0, s);
    push_a(8'h32, 1'b0, s);
    push_a(8'h33, 1'b0, s);
    push_a(8'h34, 1'b0, s);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = 8'h41;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_stall_in_ready", bus_a.in_ready,  0);
      check("t3_stall_valid",    bus_a.out_valid, 1);
      check("t3_stall_data",     bus_a.out_data,  32'h34333231);
      step();
    end
    bus_a.out_ready = 1'b1;
    #1;
    check("t3_release_in_ready", bus_a.in_ready, 1);
    step();
    #1;
    check("t3_lane0_valid", bus_a.out_valid, 0);
    check("t3_lane0_data",  bus_a.out_data,  32'h00000041);
    push_a(8'h42, 1'b0, s);
    push_a(8'h43, 1'b0, s);
    push_a(8'h44, 1'b0, s);
    idle_a();
    #1;
    check("t3_next_data",  bus_a.out_data,  32'h44434241);
    check("t3_next_count", bus_a.out_count, 4);
    step();

    // Streaming across group boundaries
    stalls_total = 0;
    for (int i = 1; i <= 12; i++) begin
      push_a(8'(i), 1'b0, s);
      stalls_total += s;
      if (i % 4 == 0) begin
        check("t4_valid", bus_a.out_valid, 1);
        check("t4_data",  bus_a.out_data,  exp_grp[i/4-1]);
        check("t4_count", bus_a.out_count, 4);
      end
    end
    idle_a();
    check("t4_stalls", stalls_total, 0);
    step();

    // Single-lane instance: every element is its own group
    bus_b.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_data  = b_vals[j];
      #1;
      check("t5_in_ready", bus_b.in_ready, 1);
      step();
      check("t5_valid", bus_b.out_valid, 1);
      check("t5_data",  bus_b.out_data,  b_vals[j]);
      check("t5_count", bus_b.out_count, 1);
    end
    bus_b.in_valid = 1'b0;
    step();
    check("t5_drain_valid", bus_b.out_valid, 0);

    // Asynchronous reset mid-group
    push_a(8'h55, 1'b0, s);
    push_a(8'h66, 1'b0, s);
    idle_a();
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_valid",    bus_a.out_valid, 0);
    check("t6_rst_data",     bus_a.out_data,  0);
    check("t6_rst_count",    bus_a.out_count, 0);
    check("t6_rst_in_ready", bus_a.in_ready,  0);
    step();
    rst = 1'b0;
    push_a(8'h01, 1'b0, s);
    push_a(8'h02, 1'b0, s);
    push_a(8'h03, 1'b0, s);
    push_a(8'h04, 1'b0, s);
    idle_a();
    #1;
    check("t6_after_valid", bus_a.out_valid, 1);
    check("t6_after_data",  bus_a.out_data,  32'h04030201);
    check("t6_after_count", bus_a.out_count, 4);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/split_network.md
Name: split_network

Overview:
- Inverse of the lane-merge datapath: collects a serial stream of BIT_WIDTH elements and distributes them into NUM_OUTPUTS parallel lanes.
- Presents the packed lane vector downstream with a valid/ready handshake. Feeds per-lane PE inputs and wide-operand consumers from narrow buffers.
- Supports early group termination (in_last); unfilled lanes are zero-padded.

Parameters:
NUM_OUTPUTS, 18, number of lanes per output group (>=1)
BIT_WIDTH, 8, bit width of each element
CNT_WIDTH, derived = ceil(log2(NUM_OUTPUTS+1)), width of lane count (5 at default); localparam, not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  input element valid
in_ready  output  1  input element can be accepted
in_data  input  BIT_WIDTH  input element
in_last  input  1  element ends current group early; qualified by in_valid
out_valid  output  1  packed group valid
out_ready  input  1  downstream accepts group
out_data  output  NUM_OUTPUTS*BIT_WIDTH  packed group; lane i at [i*BIT_WIDTH +: BIT_WIDTH]
out_count  output  CNT_WIDTH  number of filled lanes in group (1..NUM_OUTPUTS)

Behaviour:
- Reset (async, immediate):
  - state=FILL, lane index=0, out_data=0, out_count=0, out_valid=0.
  - in_ready=0 while rst is high.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_data and out_count are stable while out_valid=1 and out_ready=0.
- State FILL:
  - in_ready=1, out_valid=0.
  - An accepted element is written to lane[idx], and idx increments.
  - If idx==NUM_OUTPUTS-1 or in_last=1: go to HOLD, set out_count=idx+1, and reset idx to 0.
- State HOLD:
  - out_valid=1.
  - in_ready=out_ready (combinational pass-through; no path from in_valid to out_valid).
  - On output transfer, the buffer clears to 0 and out_count clears to 0.
    - If an element is accepted in the same cycle, it is written to lane 0 of the cleared buffer and idx=1.
    - If that element completes a group (NUM_OUTPUTS==1 or in_last=1): remain in HOLD with out_count=1.
    - Otherwise: go to FILL.
  - On output transfer with no input accepted: go to FILL.
  - Without output transfer: no state change; inputs are stalled.
- Latency: out_valid rises the cycle after the completing element is accepted. Throughput is one element per cycle, including across group boundaries via the HOLD pass-through.
- Zero padding: lanes >= out_count read 0, guaranteed by the clear on consumption and by reset.
- in_last on the final lane (idx==NUM_OUTPUTS-1) behaves the same as a normal full group.
- in_last and in_data are ignored when in_valid=0.
- Reset asserted mid-group discards the partial group and any held group; no output transfer occurs.
- No arithmetic is performed; the data path is pure lane steering plus a down-counter-free index (0..NUM_OUTPUTS-1, no wrap beyond).

Test Plan (NUM_OUTPUTS=4, BIT_WIDTH=8 unless noted):
- Full group: send 0x11,0x22,0x33,0x44 back-to-back with out_ready=1. Required: out_valid exactly 1 cycle after 0x44 is accepted; out_data=0x44332211; out_count=4.
- Early terminate: send 0xA1,0xA2 with in_last on 0xA2. Required: out_data=0x0000A2A1, out_count=2; a following full group shows no stale lanes.
- Backpressure: complete a group with out_ready=0 for 5 cycles while in_valid=1. Required: in_ready=0 and out_data stable throughout; when out_ready rises, the next element lands in lane 0 in that same cycle; no element lost or duplicated.
- Streaming: 12 elements 0x01..0x0C, in_valid and out_ready held at 1. Required: three groups 0x04030201, 0x08070605, 0x0C0B0A09; no input bubble at group boundaries.
- Degenerate (NUM_OUTPUTS=1): continuous stream 0x10,0x20,0x30. Required: out_valid stays 1 with out_data updating every cycle; out_count=1 each time.
- Reset mid-group: accept 0x55,0x66, then pulse rst asynchronously between edges. Required: out_valid=0 and out_data=0 immediately; a subsequent group 0x01..0x04 yields 0x04030201.
